// File: rtl/aes_io_pkg.sv
// Shared widths, index type and output-side state encodings for the AES
// output path.
package aes_io_pkg;

  localparam int BYTE_W = 8;
  localparam int BLK_W  = 128;
  localparam int NBYTES = 16;
  localparam int CNT_W  = $clog2(NBYTES);

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [BLK_W-1:0]  block_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t LAST_IDX = cnt_t'(NBYTES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

endpackage

// File: rtl/output_interface_if.sv
// Bundle between the AES engine / host side and the output serializer.
// The master drives done/cipher/rd; the slave returns the byte stream and status.
interface output_interface_if;
  import aes_io_pkg::*;

  logic   transformer_done;
  block_t cipher_in;
  logic   rd;
  byte_t  dout;
  logic   dout_valid;
  logic   dout_last;
  logic   avail;
  logic   overrun;

  modport master (
    output transformer_done, cipher_in, rd,
    input  dout, dout_valid, dout_last, avail, overrun
  );

  modport slave (
    input  transformer_done, cipher_in, rd,
    output dout, dout_valid, dout_last, avail, overrun
  );

endinterface

// File: rtl/byte_serializer.sv
// Holds one 128-bit block and emits it one byte per pop, MSB byte first.
// A load on the same edge as a pop emits from the old block, then replaces it.
module byte_serializer
  import aes_io_pkg::*;
(
  input  logic   clk,
  input  logic   rst_,
  input  logic   i_load,
  input  block_t i_block,
  input  logic   i_pop,
  output byte_t  o_dout,
  output logic   o_valid,
  output logic   o_last,
  output logic   o_at_last
);

  block_t r_buf;
  cnt_t   r_cnt;
  byte_t  r_dout;
  logic   r_valid;
  logic   r_last;

  byte_t  w_bytes [NBYTES];
  logic   w_at_last;

  // Byte 0 is the most significant byte of the block.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign w_bytes[gi] = r_buf[BLK_W-1-gi*BYTE_W -: BYTE_W];
    end
  endgenerate

  assign w_at_last = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= i_pop;
      r_last  <= i_pop & w_at_last;
      if (i_pop) begin
        r_dout <= w_bytes[r_cnt];
        r_cnt  <= r_cnt + cnt_t'(1);
      end
      if (i_load) begin
        r_buf <= i_block;
        r_cnt <= '0;
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_last    = r_last;
  assign o_at_last = w_at_last;

endmodule

// File: rtl/output_interface.sv
// Captures an AES result on each rising edge of transformer_done and streams
// it to the host one byte per rd, flagging results dropped while one is pending.
module output_interface
  import aes_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst_,
  output_interface_if.slave  bus
);

  logic       r_done_q;
  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic       r_overrun;

  logic       w_edge;
  logic       w_sending;
  logic       w_pop;
  logic       w_at_last;
  logic       w_last_pop;
  logic       w_load;
  logic       w_drop;
  byte_t      w_dout;
  logic       w_valid;
  logic       w_last;

  assign w_edge     = bus.transformer_done & ~r_done_q;
  assign w_sending  = (r_state == S_SEND);
  assign w_pop      = w_sending & bus.rd;
  assign w_last_pop = w_pop & w_at_last;
  // The final pop frees the buffer on the same edge, so a coincident result is kept.
  assign w_load     = w_edge & (~w_sending | w_last_pop);
  assign w_drop     = w_edge & w_sending & ~w_last_pop;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_next = S_SEND;
      S_SEND:  if (w_last_pop && !w_load) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Done copy resets high so a level already at 1 after reset is not an edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_done_q  <= 1'b1;
      r_state   <= S_IDLE;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= bus.transformer_done;
      r_state  <= w_state_next;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  byte_serializer u_ser (
    .clk       (clk),
    .rst_      (rst_),
    .i_load    (w_load),
    .i_block   (bus.cipher_in),
    .i_pop     (w_pop),
    .o_dout    (w_dout),
    .o_valid   (w_valid),
    .o_last    (w_last),
    .o_at_last (w_at_last)
  );

  assign bus.dout       = w_dout;
  assign bus.dout_valid = w_valid;
  assign bus.dout_last  = w_last;
  assign bus.avail      = w_sending;
  assign bus.overrun    = r_overrun;

endmodule

// File: doc/output_interface.md
OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_  input  1  asynchronous active-low reset.
REQ-004 transformer_done  input  1  AES engine done level; 1 = result valid/idle, 0 = busy.
REQ-005 cipher_in  input  128  AES engine ciphertext, valid while transformer_done=1.
REQ-006 rd  input  1  host byte-pull request, sampled each clk.
REQ-007 dout  output  8  ciphertext byte.
REQ-008 dout_valid  output  1  dout holds a new byte this cycle (single-cycle per byte).
REQ-009 dout_last  output  1  asserted with dout_valid on byte 16 only.
REQ-010 avail  output  1  a captured block is pending readout.
REQ-011 overrun  output  1  sticky; a result was dropped while a block was pending.

Function
REQ-012 SHALL detect the transformer_done rising edge by comparing it against a registered copy; the first cycle after reset SHALL NOT count as an edge (registered copy resets to 1).
REQ-013 States SHALL be S_IDLE (no block) and S_SEND (block pending); reset state S_IDLE.
REQ-014 On an edge in S_IDLE at clock N: the buffer loads cipher_in, the byte counter clears to 0, the state becomes S_SEND, and avail=1 is visible after edge N.
REQ-015 In S_SEND, rd=1 at edge N SHALL drive dout=buffer byte[counter], with dout_valid=1 after edge N for exactly one cycle, then increment the counter (4-bit).
REQ-016 Byte order SHALL be MSB first: byte 0 = cipher_in[127:120], byte 15 = cipher_in[7:0].
REQ-017 rd=0 SHALL stall without loss; dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-018 The pop of byte 15 SHALL assert dout_last with dout_valid, wrap the counter to 0, and return to S_IDLE (avail=0 on the same edge).
REQ-019 rd in S_IDLE SHALL be ignored: no dout_valid, and dout is unchanged.
REQ-020 An edge in S_SEND while not popping byte 15 SHALL NOT alter the buffer or counter, and SHALL set overrun=1.
REQ-021 An edge on the same clock as the byte-15 pop SHALL capture the new block, and the state SHALL stay S_SEND with avail=1; overrun is unaffected.
REQ-022 overrun SHALL clear only on reset.

Reset
REQ-023 When rst_=0 at any time, including mid-readout: state=S_IDLE, counter=0, buffer=0, dout=0, dout_valid=0, dout_last=0, avail=0, overrun=0, and the done register=1.
REQ-024 After rst_ deasserts, the first capture SHALL require a fresh 0->1 transition of transformer_done.

Structure
REQ-025 Shared package aes_io_pkg SHALL hold BYTE_W=8, BLK_W=128, NBYTES=16, and the output-side state encodings.
REQ-026 One sub-module, byte_serializer (128-bit buffer, 4-bit counter, byte mux, last flag), SHALL be instantiated; the FSM and edge detection stay in output_interface.

Verification
REQ-027 Reset, then hold transformer_done=1 -> avail=0, with no dout_valid ever.
REQ-028 Apply done 0->1 with cipher_in=69c4e0d86a7b0430d8cdb78070b4c55a, then rd=1 for 16 cycles -> dout sequence 69,c4,e0,...,c5,5a, each with dout_valid, dout_last only on 5a, then avail=0.
REQ-029 Same block with rd toggling 1,0,1,0 -> the same 16 bytes in order, no duplicates, and dout_valid=0 on stall cycles.
REQ-030 A second done edge after byte 3 with cipher_in=00..00 -> overrun=1, and the remaining bytes are from the first block.
REQ-031 Pull rd=1 for 5 bytes, then rst_=0 for 1 cycle -> all outputs 0 and avail=0; the next done edge restarts from byte 0.
REQ-032 A done edge coincident with the byte-15 pop -> avail stays 1, the next pop yields byte 0 of the new block, and overrun=0.
